// File: rtl/difftest_pkg.sv
// Shared types for the multi-lane difftest commit queue: the buffered record,
// instruction length and the queue controller states.
package difftest_pkg;

    localparam int XLEN       = 32;
    localparam int ILEN_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] next_pc;
        logic            skip;
        logic            halt;
    } commit_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_DRAIN,
        ST_HALTED
    } dq_state_e;

endpackage

// File: rtl/difftest_mw_fifo.sv
// Circular record FIFO with WR_PORTS contiguous write slots per cycle and one read.
// Pointers carry an extra wrap bit so count = wrPtr - rdPtr spans 0..DEPTH.
module difftest_mw_fifo
    import difftest_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WR_PORTS = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [AW:0] wr_cnt_i,
    input  commit_rec_t wr_rec_i [WR_PORTS],
    input  logic        rd_en_i,
    output commit_rec_t head_o,
    output logic [AW:0] count_o
);

    commit_rec_t mem_q [DEPTH];
    logic [AW:0] wrPtr_q;
    logic [AW:0] rdPtr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_q + wr_cnt_i;
            if (rd_en_i) begin
                rdPtr_q <= rdPtr_q + (AW+1)'(1);
            end
        end
    end

    // Slot k lands k entries past the write pointer; the index wraps at DEPTH.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < WR_PORTS; k++) begin
            if ((AW+1)'(k) < wr_cnt_i) begin
                mem_q[wrPtr_q[AW-1:0] + AW'(k)] <= wr_rec_i[k];
            end
        end
    end

    assign head_o  = mem_q[rdPtr_q[AW-1:0]];
    assign count_o = wrPtr_q - rdPtr_q;

endmodule

// File: rtl/difftest_commit_queue.sv
// Multi-lane difftest tap: resolves next_pc from the following commit and streams
// records out one per cycle. Optional DIFFTEST_SKIP_EN carries the MMIO skip flag.
module difftest_commit_queue
    import difftest_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int COMMIT_WIDTH = 2,
    parameter int DEPTH        = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [COMMIT_WIDTH-1:0]            cm_valid,
    input  logic [COMMIT_WIDTH*DATA_WIDTH-1:0] cm_pc,
    input  logic [COMMIT_WIDTH*DATA_WIDTH-1:0] cm_instr,
    input  logic [COMMIT_WIDTH-1:0]            cm_skip,
    input  logic                               halt,
    output logic                               cm_ready,
    output logic                               diff_valid,
    input  logic                               diff_ready,
    output logic [DATA_WIDTH-1:0]              diff_pc,
    output logic [DATA_WIDTH-1:0]              diff_instr,
    output logic [DATA_WIDTH-1:0]              diff_next_pc,
    output logic                               diff_skip,
    output logic                               diff_halt,
    output logic [$clog2(DEPTH):0]             occupancy,
    output logic                               err
);

    localparam int AW = $clog2(DEPTH);

    dq_state_e   state_q, state_d;
    commit_rec_t pendRec_q, pendRec_d;
    logic        err_q;

    commit_rec_t elem [COMMIT_WIDTH+1];
    commit_rec_t wrRec [COMMIT_WIDTH];
    commit_rec_t head;
    logic [AW:0] wrCnt;
    logic [AW:0] fifoCount;
    int          nValid;
    int          laneIdx;
    int          chainLen;
    logic        seenGap;
    logic        contig;
    logic        hasPend;
    logic        canCommit;
    logic        accept;
    logic        errSet;
    logic        pop;

    // Lane valids must be a solid run from lane 0; nValid counts that run.
    always_comb begin
        nValid  = 0;
        seenGap = 1'b0;
        contig  = 1'b1;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (cm_valid[k]) begin
                if (seenGap) contig = 1'b0;
                else         nValid++;
            end else begin
                seenGap = 1'b1;
            end
        end
    end

    assign canCommit = (state_q == ST_IDLE) || (state_q == ST_PEND);
    assign cm_ready  = canCommit && ((DEPTH - int'(fifoCount)) >= COMMIT_WIDTH);
    assign accept    = cm_ready && contig && (cm_valid != '0);
    assign errSet    = (cm_valid != '0) && (state_q != ST_HALTED) && !(cm_ready && contig);
    assign hasPend   = (state_q == ST_PEND);

    // Chain = {pending, lane0..laneN-1}; each element but the last gets its successor's PC.
    always_comb begin
        laneIdx = 0;
        for (int k = 0; k <= COMMIT_WIDTH; k++) begin
            laneIdx = hasPend ? k - 1 : k;
            elem[k] = '0;
            if (hasPend && k == 0) begin
                elem[k] = pendRec_q;
            end else if (laneIdx < COMMIT_WIDTH) begin
                elem[k].pc    = cm_pc[laneIdx*DATA_WIDTH +: DATA_WIDTH];
                elem[k].instr = cm_instr[laneIdx*DATA_WIDTH +: DATA_WIDTH];
`ifdef DIFFTEST_SKIP_EN
                elem[k].skip  = cm_skip[laneIdx];
`endif
            end
        end
    end

    always_comb begin
        chainLen  = 0;
        wrCnt     = '0;
        pendRec_d = pendRec_q;
        state_d   = state_q;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            wrRec[j]         = elem[j];
            wrRec[j].next_pc = elem[j+1].pc;
            wrRec[j].halt    = 1'b0;
        end
        case (state_q)
            ST_IDLE, ST_PEND: begin
                if (accept) begin
                    chainLen  = nValid + (hasPend ? 1 : 0);
                    wrCnt     = (AW+1)'(chainLen - 1);
                    pendRec_d = elem[chainLen-1];
                end
                if (halt) begin
                    state_d = (accept || hasPend) ? ST_DRAIN : ST_HALTED;
                end else if (accept) begin
                    state_d = ST_PEND;
                end
            end
            ST_DRAIN: begin
                if (int'(fifoCount) < DEPTH) begin
                    wrCnt            = (AW+1)'(1);
                    wrRec[0]         = pendRec_q;
                    wrRec[0].next_pc = pendRec_q.pc + XLEN'(ILEN_BYTES);
                    wrRec[0].halt    = 1'b1;
                    state_d          = ST_HALTED;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pendRec_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pendRec_q <= pendRec_d;
            if (errSet) err_q <= 1'b1;
        end
    end

    difftest_mw_fifo #(
        .DEPTH    (DEPTH),
        .WR_PORTS (COMMIT_WIDTH)
    ) u_fifo (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .wr_cnt_i (wrCnt),
        .wr_rec_i (wrRec),
        .rd_en_i  (pop),
        .head_o   (head),
        .count_o  (fifoCount)
    );

    // Data outputs are masked while empty so stale FIFO contents never leak out.
    assign diff_valid   = (fifoCount != '0);
    assign pop          = diff_valid && diff_ready;
    assign diff_pc      = diff_valid ? head.pc      : '0;
    assign diff_instr   = diff_valid ? head.instr   : '0;
    assign diff_next_pc = diff_valid ? head.next_pc : '0;
    assign diff_halt    = diff_valid && head.halt;
    assign occupancy    = fifoCount;
    assign err          = err_q;

`ifdef DIFFTEST_SKIP_EN
    assign diff_skip = diff_valid && head.skip;
`else
    logic unusedSkip;
    assign unusedSkip = ^cm_skip ^ head.skip;
    assign diff_skip  = 1'b0;
`endif

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Directed bench for difftest_commit_queue (COMMIT_WIDTH=2, DEPTH=8); the skip
// expectation follows DIFFTEST_SKIP_EN.
module tb_difftest_commit_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cm_valid;
    logic [63:0] cm_pc;
    logic [63:0] cm_instr;
    logic [1:0]  cm_skip;
    logic        halt;
    logic        cm_ready;
    logic        diff_valid;
    logic        diff_ready;
    logic [31:0] diff_pc;
    logic [31:0] diff_instr;
    logic [31:0] diff_next_pc;
    logic        diff_skip;
    logic        diff_halt;
    logic [3:0]  occupancy;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    difftest_commit_queue #(
        .DATA_WIDTH   (32),
        .COMMIT_WIDTH (2),
        .DEPTH        (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cm_valid     (cm_valid),
        .cm_pc        (cm_pc),
        .cm_instr     (cm_instr),
        .cm_skip      (cm_skip),
        .halt         (halt),
        .cm_ready     (cm_ready),
        .diff_valid   (diff_valid),
        .diff_ready   (diff_ready),
        .diff_pc      (diff_pc),
        .diff_instr   (diff_instr),
        .diff_next_pc (diff_next_pc),
        .diff_skip    (diff_skip),
        .diff_halt    (diff_halt),
        .occupancy    (occupancy),
        .err          (err)
    );

    // Drive one commit cycle, then wait until just after the capturing edge.
    task automatic applyStimulus(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                                 input logic [1:0] sk, input logic h);
        cm_valid = v;
        cm_pc    = {p1, p0};
        cm_instr = {p1[15:0], 16'h0013, p0[15:0], 16'h0013};
        cm_skip  = sk;
        halt     = h;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Short async reset pulse between clock edges; outputs must clear immediately.
    task automatic pulseReset(input string tag);
        cm_valid = '0;
        halt     = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput({tag, "_valid"}, 32'(diff_valid), 32'd0);
        checkOutput({tag, "_occ"},   32'(occupancy),  32'd0);
        checkOutput({tag, "_err"},   32'(err),        32'd0);
        checkOutput({tag, "_pc"},    diff_pc,         32'd0);
        checkOutput({tag, "_ready"}, 32'(cm_ready),   32'd1);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        cm_valid   = '0;
        cm_pc      = '0;
        cm_instr   = '0;
        cm_skip    = '0;
        halt       = 1'b0;
        diff_ready = 1'b0;
        #2;
        checkOutput("rst_valid", 32'(diff_valid), 32'd0);
        checkOutput("rst_occ",   32'(occupancy),  32'd0);
        checkOutput("rst_err",   32'(err),        32'd0);
        checkOutput("rst_ready", 32'(cm_ready),   32'd1);
        checkOutput("rst_next",  diff_next_pc,    32'd0);
        #1;
        rst_n = 1'b1;

        $display("[TB] two-lane commit then single commit");
        applyStimulus(2'b11, 32'h8000_0000, 32'h8000_0004, 2'b00, 1'b0);
        checkOutput("t1_occ1",  32'(occupancy), 32'd1);
        checkOutput("t1_pc0",   diff_pc,        32'h8000_0000);
        checkOutput("t1_next0", diff_next_pc,   32'h8000_0004);
        checkOutput("t1_ins0",  diff_instr,     32'h0000_0013);
        checkOutput("t1_halt0", 32'(diff_halt), 32'd0);
        applyStimulus(2'b01, 32'h8000_0010, 32'h0, 2'b00, 1'b0);
        checkOutput("t1_occ2",  32'(occupancy), 32'd2);
        diff_ready = 1'b1;
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        checkOutput("t1_occ3",  32'(occupancy), 32'd1);
        checkOutput("t1_pc1",   diff_pc,        32'h8000_0004);
        checkOutput("t1_next1", diff_next_pc,   32'h8000_0010);
        checkOutput("t1_ins1",  diff_instr,     32'h0004_0013);
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        checkOutput("t1_empty", 32'(diff_valid), 32'd0);
        checkOutput("t1_mask",  diff_pc,         32'd0);

        $display("[TB] halt merged with final commit");
        applyStimulus(2'b01, 32'h8000_001c, 32'h0, 2'b00, 1'b0);
        checkOutput("t2_next10", diff_next_pc, 32'h8000_001c);
        applyStimulus(2'b01, 32'h8000_0020, 32'h0, 2'b00, 1'b1);
        checkOutput("t2_pc1c",   diff_pc,         32'h8000_001c);
        checkOutput("t2_next1c", diff_next_pc,    32'h8000_0020);
        checkOutput("t2_nohalt", 32'(diff_halt),  32'd0);
        checkOutput("t2_drainrdy", 32'(cm_ready), 32'd0);
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        checkOutput("t2_pc20",   diff_pc,        32'h8000_0020);
        checkOutput("t2_next24", diff_next_pc,   32'h8000_0024);
        checkOutput("t2_halt",   32'(diff_halt), 32'd1);
        applyStimulus(2'b11, 32'h8000_0030, 32'h8000_0034, 2'b00, 1'b0);
        checkOutput("t2_ignored", 32'(occupancy), 32'd0);
        checkOutput("t2_noerr",   32'(err),       32'd0);

        $display("[TB] fill until backpressure, then overflow");
        pulseReset("t3rst");
        diff_ready = 1'b0;
        applyStimulus(2'b11, 32'h9000_0000, 32'h9000_0004, 2'b00, 1'b0);
        applyStimulus(2'b11, 32'h9000_0008, 32'h9000_000c, 2'b00, 1'b0);
        applyStimulus(2'b11, 32'h9000_0010, 32'h9000_0014, 2'b00, 1'b0);
        checkOutput("t3_occ5",  32'(occupancy), 32'd5);
        checkOutput("t3_rdy5",  32'(cm_ready),  32'd1);
        applyStimulus(2'b11, 32'h9000_0018, 32'h9000_001c, 2'b00, 1'b0);
        checkOutput("t3_occ7",  32'(occupancy), 32'd7);
        checkOutput("t3_rdy7",  32'(cm_ready),  32'd0);
        checkOutput("t3_err0",  32'(err),       32'd0);
        applyStimulus(2'b11, 32'h9000_0020, 32'h9000_0024, 2'b00, 1'b0);
        checkOutput("t3_ovf_occ", 32'(occupancy), 32'd7);
        checkOutput("t3_ovf_err", 32'(err),       32'd1);
        diff_ready = 1'b1;
        cm_valid   = '0;
        for (int k = 0; k < 7; k++) begin
            checkOutput($sformatf("t3_pc%0d", k),   diff_pc,      32'h9000_0000 + 32'(4*k));
            checkOutput($sformatf("t3_next%0d", k), diff_next_pc, 32'h9000_0004 + 32'(4*k));
            applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        end
        checkOutput("t3_drained", 32'(occupancy), 32'd0);
        applyStimulus(2'b01, 32'h9000_0040, 32'h0, 2'b00, 1'b0);
        checkOutput("t3_pendpc",   diff_pc,      32'h9000_001c);
        checkOutput("t3_pendnext", diff_next_pc, 32'h9000_0040);

        $display("[TB] non-contiguous lane valids");
        pulseReset("t4rst");
        diff_ready = 1'b0;
        applyStimulus(2'b01, 32'ha000_0100, 32'h0, 2'b00, 1'b0);
        applyStimulus(2'b10, 32'h0, 32'ha000_0200, 2'b00, 1'b0);
        checkOutput("t4_err", 32'(err),       32'd1);
        checkOutput("t4_occ", 32'(occupancy), 32'd0);
        applyStimulus(2'b01, 32'ha000_0104, 32'h0, 2'b00, 1'b0);
        checkOutput("t4_occ1", 32'(occupancy), 32'd1);
        checkOutput("t4_pc",   diff_pc,        32'ha000_0100);
        checkOutput("t4_next", diff_next_pc,   32'ha000_0104);

        $display("[TB] async reset mid-stream");
        applyStimulus(2'b11, 32'ha000_0108, 32'ha000_010c, 2'b00, 1'b0);
        applyStimulus(2'b11, 32'ha000_0110, 32'ha000_0114, 2'b00, 1'b0);
        checkOutput("t5_occ5", 32'(occupancy), 32'd5);
        pulseReset("t5rst");

        $display("[TB] skip flag");
        applyStimulus(2'b11, 32'ha000_0000, 32'ha000_0004, 2'b01, 1'b0);
        checkOutput("t6_pc", diff_pc, 32'ha000_0000);
`ifdef DIFFTEST_SKIP_EN
        checkOutput("t6_skip", 32'(diff_skip), 32'd1);
`else
        checkOutput("t6_skip", 32'(diff_skip), 32'd0);
`endif

        $display("[TB] halt with nothing pending");
        pulseReset("t7rst");
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b1);
        checkOutput("t7_rdy", 32'(cm_ready),  32'd0);
        checkOutput("t7_occ", 32'(occupancy), 32'd0);
        applyStimulus(2'b01, 32'hb000_0000, 32'h0, 2'b00, 1'b0);
        checkOutput("t7_ign_occ", 32'(occupancy), 32'd0);
        checkOutput("t7_ign_err", 32'(err),       32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
